// File: rtl/la_cmd_pkg.sv
// la_cmd_pkg: opcodes, ack byte and FSM states for uart_port_master (TX_ACK only with UART_PORT_MASTER_ECHO_ACK_EN)
package la_cmd_pkg;
  localparam logic [7:0] CMD_WRITE_DEF = 8'h57;
  localparam logic [7:0] CMD_READ_DEF  = 8'h52;
  localparam logic [7:0] ACK_BYTE_DEF  = 8'h4B;
  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WR_STROBE,
    RD_SETUP,
    RD_STROBE,
    TX_RESULT
`ifdef UART_PORT_MASTER_ECHO_ACK_EN
    , TX_ACK
`endif
  } state_t;
endpackage

// File: rtl/uart_port_master.sv
// uart_port_master: UART command bytes to port read/write cycles; UART_PORT_MASTER_ECHO_ACK_EN echoes ACK_BYTE after writes
module uart_port_master
  import la_cmd_pkg::*;
#(
  parameter logic [7:0] CMD_WRITE = CMD_WRITE_DEF,
  parameter logic [7:0] CMD_READ  = CMD_READ_DEF,
  parameter logic [7:0] ACK_BYTE  = ACK_BYTE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_data_present,
  output logic       rx_read,
  output logic [7:0] tx_data,
  input  logic       tx_full,
  output logic       tx_write,
  output logic [7:0] port_id,
  output logic [7:0] port_out,
  input  logic [7:0] port_in,
  output logic       write_strobe,
  output logic       read_strobe,
  output logic       busy,
  output logic [7:0] bad_cmd_count
);
  state_t state, state_nxt;
  logic   op_read;
  logic   fetch;
  logic   valid_op;
  logic   tx_state;
  logic   ack_load;
  assign fetch    = (state == IDLE || state == GET_ADDR || state == GET_DATA) && rx_data_present && !rx_read;
  assign valid_op = rx_data == CMD_WRITE || rx_data == CMD_READ;
  assign busy     = state != IDLE;
`ifdef UART_PORT_MASTER_ECHO_ACK_EN
  assign tx_state = state == TX_RESULT || state == TX_ACK;
  assign ack_load = state == WR_STROBE;
`else
  assign tx_state = state == TX_RESULT;
  assign ack_load = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = fetch && valid_op ? GET_ADDR : IDLE;
      GET_ADDR:  state_nxt = !fetch ? GET_ADDR : op_read ? RD_SETUP : GET_DATA;
      GET_DATA:  state_nxt = fetch ? WR_STROBE : GET_DATA;
`ifdef UART_PORT_MASTER_ECHO_ACK_EN
      WR_STROBE: state_nxt = TX_ACK;
      TX_ACK:    state_nxt = tx_full ? TX_ACK : IDLE;
`else
      WR_STROBE: state_nxt = IDLE;
`endif
      RD_SETUP:  state_nxt = RD_STROBE;
      RD_STROBE: state_nxt = TX_RESULT;
      TX_RESULT: state_nxt = tx_full ? TX_RESULT : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nxt;
  // All pulses are registered one cycle behind the state that decides them,
  // so a pop and a strobe can never share a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_read       <= 1'b0;
      write_strobe  <= 1'b0;
      read_strobe   <= 1'b0;
      tx_write      <= 1'b0;
      port_id       <= 8'h00;
      port_out      <= 8'h00;
      tx_data       <= 8'h00;
      bad_cmd_count <= 8'h00;
      op_read       <= 1'b0;
    end else begin
      rx_read      <= fetch;
      write_strobe <= state == WR_STROBE;
      read_strobe  <= state == RD_SETUP;
      tx_write     <= tx_state && !tx_full;
      if (fetch && state == IDLE) begin
        op_read <= rx_data == CMD_READ;
        if (!valid_op && bad_cmd_count != 8'hFF)
          bad_cmd_count <= bad_cmd_count + 8'd1;
      end
      if (fetch && state == GET_ADDR)
        port_id <= rx_data;
      if (fetch && state == GET_DATA)
        port_out <= rx_data;
      if (state == RD_STROBE || ack_load)
        tx_data <= state == RD_STROBE ? port_in : ACK_BYTE;
    end
  end
endmodule

// File: tb/tb_uart_port_master.sv
// tb_uart_port_master: directed self-checking bench for uart_port_master
module tb_uart_port_master;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_present = 1'b0;
  logic       rx_read;
  logic [7:0] tx_data;
  logic       tx_full = 1'b0;
  logic       tx_write;
  logic [7:0] port_id;
  logic [7:0] port_out;
  logic [7:0] port_in = 8'h00;
  logic       write_strobe;
  logic       read_strobe;
  logic       busy;
  logic [7:0] bad_cmd_count;
  uart_port_master dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_data_present(rx_data_present),
    .rx_read(rx_read),
    .tx_data(tx_data),
    .tx_full(tx_full),
    .tx_write(tx_write),
    .port_id(port_id),
    .port_out(port_out),
    .port_in(port_in),
    .write_strobe(write_strobe),
    .read_strobe(read_strobe),
    .busy(busy),
    .bad_cmd_count(bad_cmd_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) port_in <= port_id ^ 8'hC0;
  logic [7:0] rx_q[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, pops = 0, pop_cyc = 0, pid_cyc = 0;
  int wr_n = 0, wr_cyc = 0, rd_n = 0, rd_cyc = 0, tx_n = 0, tx_cyc = 0;
  int onehot_err = 0, pace_err = 0;
  logic [7:0] wr_id = 0, wr_out = 0, rd_id = 0, tx_last = 0, pid_q = 0;
  logic rx_read_q = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if ($countones({write_strobe, read_strobe, rx_read, tx_write}) > 1) onehot_err++;
    if (rx_read && rx_read_q) pace_err++;
    rx_read_q = rx_read;
    if (port_id != pid_q) pid_cyc = cyc;
    pid_q = port_id;
    if (rx_read && rx_q.size() != 0) begin
      rx_q.delete(0);
      pops++;
      pop_cyc = cyc;
    end
    if (write_strobe) begin
      wr_n++;
      wr_id = port_id;
      wr_out = port_out;
      wr_cyc = cyc;
    end
    if (read_strobe) begin
      rd_n++;
      rd_id = port_id;
      rd_cyc = cyc;
    end
    if (tx_write) begin
      tx_n++;
      tx_last = tx_data;
      tx_cyc = cyc;
    end
    rx_data_present = rx_q.size() != 0;
    rx_data = rx_q.size() != 0 ? rx_q[0] : 8'h00;
  end
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drain(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while ((rx_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({"drain_", tag}, 16'(n < budget), 16'd1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int p0, t0, n;
    repeat (3) @(negedge clk);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_pulses", 16'({rx_read, write_strobe, read_strobe, tx_write}), 16'd0);
    check("rst_port_id", 16'(port_id), 16'h00);
    check("rst_port_out", 16'(port_out), 16'h00);
    check("rst_tx_data", 16'(tx_data), 16'h00);
    check("rst_bad", 16'(bad_cmd_count), 16'h00);
    reset = 1'b0;
    @(negedge clk);
    rx_q.push_back(8'h57); rx_q.push_back(8'h0A); rx_q.push_back(8'h5A);
    drain("wr", 50);
    check("wr_count", 16'(wr_n), 16'd1);
    check("wr_id", 16'(wr_id), 16'h0A);
    check("wr_out", 16'(wr_out), 16'h5A);
    check("wr_latency", 16'(wr_cyc - pop_cyc), 16'd1);
`ifdef UART_PORT_MASTER_ECHO_ACK_EN
    check("wr_ack_count", 16'(tx_n), 16'd1);
    check("wr_ack_byte", 16'(tx_last), 16'h4B);
`else
    check("wr_no_tx", 16'(tx_n), 16'd0);
`endif
    t0 = tx_n;
    rx_q.push_back(8'h52); rx_q.push_back(8'h03);
    drain("rd", 50);
    check("rd_count", 16'(rd_n), 16'd1);
    check("rd_id", 16'(rd_id), 16'h03);
    check("rd_after_pid", 16'(rd_cyc - pid_cyc), 16'd1);
    check("rd_tx_count", 16'(tx_n - t0), 16'd1);
    check("rd_tx_byte", 16'(tx_last), 16'hC3);
    check("rd_latency", 16'(tx_cyc - pop_cyc), 16'd3);
    check("hold_port_out", 16'(port_out), 16'h5A);
    check("rd_no_write", 16'(wr_n), 16'd1);
    t0 = tx_n;
    tx_full = 1'b1;
    rx_q.push_back(8'h52); rx_q.push_back(8'h07);
    repeat (12) @(negedge clk);
    check("bp_no_push", 16'(tx_n - t0), 16'd0);
    check("bp_busy", 16'(busy), 16'd1);
    check("bp_tx_write_low", 16'(tx_write), 16'd0);
    tx_full = 1'b0;
    drain("bp", 50);
    check("bp_one_push", 16'(tx_n - t0), 16'd1);
    check("bp_tx_byte", 16'(tx_last), 16'hC7);
    p0 = pops;
    t0 = tx_n;
    for (int i = 0; i < 300; i++) rx_q.push_back(8'h00);
    drain("bad", 1000);
    check("bad_count", 16'(bad_cmd_count), 16'hFF);
    check("bad_pops", 16'(pops - p0), 16'd300);
    check("bad_no_wr", 16'(wr_n), 16'd1);
    check("bad_no_rd", 16'(rd_n), 16'd2);
    check("bad_no_tx", 16'(tx_n - t0), 16'd0);
    rx_q.push_back(8'h57); rx_q.push_back(8'h0A);
    n = 0;
    while (rx_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("mid_pending", 16'(n < 50), 16'd1);
    check("mid_busy", 16'(busy), 16'd1);
    check("mid_port_id", 16'(port_id), 16'h0A);
    reset = 1'b1;
    @(negedge clk);
    p0 = pops;
    rx_q.push_back(8'h52); rx_q.push_back(8'h01);
    repeat (3) @(negedge clk);
    check("mid_rst_no_pop", 16'(pops - p0), 16'd0);
    check("mid_rst_busy", 16'(busy), 16'd0);
    check("mid_rst_port_id", 16'(port_id), 16'h00);
    check("mid_rst_port_out", 16'(port_out), 16'h00);
    check("mid_rst_tx_data", 16'(tx_data), 16'h00);
    check("mid_rst_bad", 16'(bad_cmd_count), 16'h00);
    reset = 1'b0;
    t0 = tx_n;
    drain("post_rst", 50);
    check("post_rd_count", 16'(rd_n), 16'd3);
    check("post_rd_id", 16'(rd_id), 16'h01);
    check("post_tx_count", 16'(tx_n - t0), 16'd1);
    check("post_tx_byte", 16'(tx_last), 16'hC1);
    check("post_no_wr", 16'(wr_n), 16'd1);
    check("one_hot", 16'(onehot_err), 16'd0);
    check("pacing", 16'(pace_err), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_port_master.md
UART_PORT_MASTER -- requirements
Module: uart_port_master

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CMD_WRITE, 8'h57 ('W'), opcode for a port write.
- CMD_READ, 8'h52 ('R'), opcode for a port read.
- ACK_BYTE, 8'h4B ('K'), write-acknowledge byte.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- rx_data  in  8  head byte of the UART RX buffer.
- rx_data_present  in  1  RX buffer non-empty.
- rx_read  out  1  pop RX buffer, one-cycle pulse.
- tx_data  out  8  byte to the UART TX buffer.
- tx_full  in  1  TX buffer full.
- tx_write  out  1  push TX buffer, one-cycle pulse.
- port_id  out  8  port address.
- port_out  out  8  write data.
- port_in  in  8  read data; the responder registers it one cycle after port_id.
- write_strobe  out  1  port write qualifier.
- read_strobe  out  1  port read qualifier.
- busy  out  1  high in every state except IDLE.
- bad_cmd_count  out  8  count of unrecognised opcodes, saturating.

Function
REQ-003 The FSM SHALL have states IDLE, GET_ADDR, GET_DATA, WR_STROBE, RD_SETUP, RD_STROBE, TX_RESULT and TX_ACK.
REQ-004 Byte fetch in IDLE, GET_ADDR and GET_DATA:
- Fetch occurs when rx_data_present=1 and rx_read=0.
- On fetch, capture rx_data and pulse rx_read for exactly one cycle.
- A fetch SHALL NOT occur in the cycle immediately after a pop.
REQ-005 IDLE transitions:
- Opcode equal to CMD_WRITE or CMD_READ -> GET_ADDR.
- Any other opcode -> stay in IDLE and increment bad_cmd_count, which saturates at 8'hFF.
REQ-006 GET_ADDR SHALL load port_id from the fetched byte, then go to GET_DATA (write) or RD_SETUP (read).
REQ-007 GET_DATA SHALL load port_out, then go to WR_STROBE.
REQ-008 WR_STROBE SHALL assert write_strobe for exactly one cycle with port_id and port_out stable.
- Next state is TX_ACK when ECHO_ACK_EN is defined, otherwise IDLE.
REQ-009 Read sequence:
- RD_SETUP holds port_id for one cycle with no strobe.
- RD_STROBE asserts read_strobe for one cycle and captures port_in at the end of that cycle.
- Next state is TX_RESULT.
REQ-010 TX_RESULT and TX_ACK:
- While tx_full=1, wait with tx_write=0.
- When tx_full=0, drive tx_data (captured read byte or ACK_BYTE) and pulse tx_write for one cycle, then go to IDLE.
REQ-011 port_id and port_out SHALL hold their last values between transactions.
REQ-012 At most one of write_strobe, read_strobe, rx_read and tx_write SHALL be high in any cycle.
REQ-013 Latency with no back-pressure:
- Read: last fetch to tx_write is 3 cycles.
- Write: data fetch to write_strobe is 1 cycle.

Reset
REQ-014 Reset SHALL force, at the next clock edge, regardless of state mid-transaction:
- state=IDLE;
- all strobes, rx_read and tx_write = 0;
- port_id, port_out, tx_data and bad_cmd_count = 8'h00.
REQ-015 A partially received command SHALL be discarded on reset; no RX bytes are popped during reset.

Configuration
REQ-016 Macro UART_PORT_MASTER_ECHO_ACK_EN:
- Defined: every completed write emits ACK_BYTE through TX_ACK.
- Undefined: the TX_ACK state and its logic are absent, and writes produce no TX traffic.

Structure
REQ-017 Package la_cmd_pkg SHALL hold the opcode constants, ACK_BYTE and the state enumeration, shared with firmware-facing blocks.
REQ-018 No sub-module is natural; the block is one FSM with a byte-fetch helper expressed inline.

Verification
REQ-019 Write: RX bytes 57,0A,5A -> one write_strobe with port_id=0A, port_out=5A; with ECHO_ACK_EN, TX receives 4B.
REQ-020 Read: RX bytes 52,03 with port_in=C3 -> read_strobe one cycle after port_id=03, then TX receives C3.
REQ-021 Back-pressure: tx_full=1 for 10 cycles during a read -> tx_write stays low; one push occurs after tx_full falls.
REQ-022 Bad opcode: 300 bytes of 00 -> bad_cmd_count=FF, no strobes, 300 pops.
REQ-023 Reset mid-op: reset after bytes 57,0A -> IDLE; a following 52,01 executes as a clean read.
REQ-024 Pacing: RX bytes present continuously -> rx_read never high in two consecutive cycles.
